hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
// - Pipeline sequencer between fetch, decoder and execute of the swt16 core.
// - Tracks in-flight register writes in a scoreboard and stalls fetch/decode on RAW hazards.
// - Drives the decoder flush and fetch hold for FLUSH_CYCLES cycles after a taken jump.
// - Issues a bubble into execute whenever decode is held or flushed.
// PARAMETERS
// - REG_IDX_WIDTH  4  register index width
// - WB_LATENCY     3  cycles from decode issue to regfile write (scoreboard depth, >=2)
// - FLUSH_CYCLES   2  cycles out_flush stays high after a jump (1..7)
// - WRITE_THROUGH  1  1: regfile forwards same-cycle write; last slot excluded from hazard check
// PORTS
// - clock               in   1    clock
// - reset               in   1    reset, asynchronous, active-high
// - in_dec_valid        in   1    decoder holds a real (non-NOP, non-flushed) instruction word
// - in_dec_src1_idx     in   RIW  decoder src1 register index
// - in_dec_src1_used    in   1    src1 is read by this instruction
// - in_dec_src2_idx     in   RIW  decoder src2 register index
// - in_dec_src2_used    in   1    src2 is read by this instruction
// - in_dec_res_idx      in   RIW  decoder result register index
// - in_dec_write_res    in   1    decoder act_write_res_to_reg
// - in_ex_jump          in   1    execute stage act_jump_to_ialu_res (jump taken this cycle)
// - out_stall           out  1    hold PC, fetch and decoder registers
// - out_flush           out  1    to decoder in_flush
// - out_bubble          out  1    execute must treat this cycle's decode actions as NOP
// - out_busy            out  2**RIW  per-register pending-write mask (debug/trace)
// - out_state           out  2    current FSM state
// BEHAVIOUR
// - Reset: state RUN, scoreboard slots invalid, flush counter 0; all outputs 0.
// - Scoreboard: WB_LATENCY slots {valid, idx}, shift by one each cycle, slot 0 = execute.
//   - Slot 0 loads in_dec_res_idx when in_dec_valid & in_dec_write_res & issue; otherwise invalid.
//   - issue = in_dec_valid & ~out_stall & ~out_flush.
//   - Last slot retires (written to regfile) and drops out.
// - Hazard: srcN_used & valid slot with idx == srcN_idx, checked over slots 0..WB_LATENCY-1.
//   - With WRITE_THROUGH=1 the last slot is excluded.
//   - Only evaluated when in_dec_valid.
// - FSM states RUN=0, STALL=1, FLUSH=2. Outputs combinational from state and inputs.
//   - RUN: hazard -> out_stall=1, out_bubble=1, next STALL; else pass-through.
//   - STALL: out_stall=out_bubble=1 while hazard persists; no hazard -> outputs 0, next RUN.
//     - Same-cycle release; stall length = cycles until producer leaves the checked slots.
//   - FLUSH: out_flush=1, out_stall=0, out_bubble=1; counter decrements; 1 -> next RUN.
//   - in_ex_jump (any state): out_flush=out_bubble=1 that cycle, out_stall=0.
//     - Load counter FLUSH_CYCLES-1; next FLUSH, or RUN if FLUSH_CYCLES==1.
//     - Jump beats hazard; jump inside FLUSH restarts counter.
// - Jump's own write (JAL link) is already in slot 0/older slots; flush never clears slots.
// - Two-cycle decoder instructions: stall holds both words; flush aborts either cycle.
// - Reset mid-stall or mid-flush: immediate return to reset values, no pending writes kept.
// - out_busy = OR of one-hot(idx) over all valid slots, incl. last.
// STRUCTURE
// - swt16_pkg: state encodings, REG_IDX_WIDTH, WB_LATENCY default.
// - Sub-module reg_scoreboard: slot shift register, compare logic, busy mask.
// - Top holds FSM and flush counter.
// TESTING
// - Reset mid-STALL: all outputs 0 next cycle; out_busy=0.
// - RAW, WB_LATENCY=3, WRITE_THROUGH=1:
//   - Issue write r3, then instr reading src1=r3 -> out_stall=1 for exactly 2 cycles, then issue.
// - No hazard:
//   - Write r3 then read r4 -> out_stall never asserts; out_busy[3]=1 for 3 cycles.
// - Jump:
//   - in_ex_jump pulse, FLUSH_CYCLES=2 -> out_flush=1 for 2 cycles.
//   - No slot loaded during flush; out_state 0->2->0.
// - Jump during STALL:
//   - Hazard on r5 and in_ex_jump same cycle -> out_stall=0, out_flush=1, state FLUSH.
// - Back-to-back jumps:
//   - Second in_ex_jump in last flush cycle -> out_flush stays high 2 more cycles.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the swt16 pipeline hazard controller.
package hazard_ctrl_pkg;

    localparam int REG_IDX_WIDTH_DEF = 4;
    localparam int WB_LATENCY_DEF    = 3;
    localparam int FLUSH_CYCLES_DEF  = 2;
    localparam int WRITE_THROUGH_DEF = 1;

    // Wide enough for FLUSH_CYCLES up to 7
    localparam int FLUSH_CNT_WIDTH   = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_e;

    // Number of scoreboard slots that can still cause a RAW hazard. With a
    // write-through regfile the oldest slot is written in the same cycle the
    // consumer reads, so it never needs to stall.
    function automatic int num_checked_slots(input int wb_latency, input int write_through);
        return (write_through != 0) ? (wb_latency - 1) : wb_latency;
    endfunction

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// In-flight register-write tracker: a shift register of {valid, idx} slots,
// slot 0 being the instruction currently in execute, plus the RAW compare and
// the per-register busy mask.
module hazard_ctrl_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int IDX_W = REG_IDX_WIDTH_DEF,
    parameter int LAT   = WB_LATENCY_DEF,
    parameter int WT    = WRITE_THROUGH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic [IDX_W-1:0]      load_idx_i,
    input  logic                  check_en_i,
    input  logic [IDX_W-1:0]      src1_idx_i,
    input  logic                  src1_used_i,
    input  logic [IDX_W-1:0]      src2_idx_i,
    input  logic                  src2_used_i,
    output logic                  hazard_o,
    output logic [2**IDX_W-1:0]   busy_o
);

    localparam int NCHK = num_checked_slots(LAT, WT);

    logic [LAT-1:0]   valid_q;
    logic [IDX_W-1:0] idx_q [LAT];
    logic             hit;
    logic [2**IDX_W-1:0] busy;

    // Advance every pending write by one stage; the oldest one retires.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                idx_q[k] <= '0;
            end
        end else begin
            valid_q  <= {valid_q[LAT-2:0], load_i};
            idx_q[0] <= load_idx_i;
            for (int k = 1; k < LAT; k++) begin
                idx_q[k] <= idx_q[k-1];
            end
        end
    end

    // Match either used source against every slot still ahead of the regfile.
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < NCHK; k++) begin
            if (valid_q[k] &&
                ((src1_used_i && (idx_q[k] == src1_idx_i)) ||
                 (src2_used_i && (idx_q[k] == src2_idx_i)))) begin
                hit = 1'b1;
            end
        end
    end

    assign hazard_o = check_en_i & hit;

    // Busy mask covers all slots, including the one being written this cycle.
    always_comb begin
        busy = '0;
        for (int k = 0; k < LAT; k++) begin
            busy[idx_q[k]] = busy[idx_q[k]] | valid_q[k];
        end
    end

    assign busy_o = busy;

endmodule

// File: rtl/hazard_ctrl.sv
// swt16 pipeline sequencer: stalls fetch/decode on RAW hazards, flushes the
// decoder after taken jumps, and injects bubbles into execute.
//
// state | meaning
// RUN   | normal issue, decode passes straight to execute
// STALL | consumer held until its producer leaves the checked slots
// FLUSH | decoder flushed for the remaining post-jump cycles
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_IDX_WIDTH = REG_IDX_WIDTH_DEF,
    parameter int WB_LATENCY    = WB_LATENCY_DEF,
    parameter int FLUSH_CYCLES  = FLUSH_CYCLES_DEF,
    parameter int WRITE_THROUGH = WRITE_THROUGH_DEF
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_dec_valid,
    input  logic [REG_IDX_WIDTH-1:0]      in_dec_src1_idx,
    input  logic                          in_dec_src1_used,
    input  logic [REG_IDX_WIDTH-1:0]      in_dec_src2_idx,
    input  logic                          in_dec_src2_used,
    input  logic [REG_IDX_WIDTH-1:0]      in_dec_res_idx,
    input  logic                          in_dec_write_res,
    input  logic                          in_ex_jump,
    output logic                          out_stall,
    output logic                          out_flush,
    output logic                          out_bubble,
    output logic [2**REG_IDX_WIDTH-1:0]   out_busy,
    output logic [1:0]                    out_state
);

    localparam logic [FLUSH_CNT_WIDTH-1:0] FLUSH_LOAD = FLUSH_CNT_WIDTH'(FLUSH_CYCLES - 1);

    hz_state_e                  state_q, state_d;
    logic [FLUSH_CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic                       hazard;
    logic                       stall_c, flush_c, bubble_c;
    logic                       issue;
    logic [2**REG_IDX_WIDTH-1:0] busy;

    hazard_ctrl_scoreboard #(
        .IDX_W (REG_IDX_WIDTH),
        .LAT   (WB_LATENCY),
        .WT    (WRITE_THROUGH)
    ) u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .load_i      (issue & in_dec_write_res),
        .load_idx_i  (in_dec_res_idx),
        .check_en_i  (in_dec_valid),
        .src1_idx_i  (in_dec_src1_idx),
        .src1_used_i (in_dec_src1_used),
        .src2_idx_i  (in_dec_src2_idx),
        .src2_used_i (in_dec_src2_used),
        .hazard_o    (hazard),
        .busy_o      (busy)
    );

    // Next state and same-cycle control outputs; a taken jump overrides everything.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        stall_c     = 1'b0;
        flush_c     = 1'b0;
        bubble_c    = 1'b0;
        if (in_ex_jump) begin
            flush_c     = 1'b1;
            bubble_c    = 1'b1;
            flush_cnt_d = FLUSH_LOAD;
            state_d     = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hazard) begin
                        stall_c  = 1'b1;
                        bubble_c = 1'b1;
                        state_d  = ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (hazard) begin
                        stall_c  = 1'b1;
                        bubble_c = 1'b1;
                    end else begin
                        state_d  = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    if (flush_cnt_q <= FLUSH_CNT_WIDTH'(1)) begin
                        flush_cnt_d = '0;
                        state_d     = ST_RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - FLUSH_CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_d     = ST_RUN;
                    flush_cnt_d = '0;
                end
            endcase
        end
    end

    // Only an instruction that neither stalls nor is flushed enters execute.
    assign issue = in_dec_valid & ~stall_c & ~flush_c;

    // FSM state and flush down-counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Controls are combinational from inputs, so hold them low while reset is asserted.
    assign out_stall  = stall_c  & ~reset;
    assign out_flush  = flush_c  & ~reset;
    assign out_bubble = bubble_c & ~reset;
    assign out_busy   = busy;
    assign out_state  = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int RIW  = 4;
    localparam int LAT  = 3;
    localparam int FC   = 2;
    localparam int WT   = 1;
    localparam int NREG = 16;

    logic            clock;
    logic            reset;
    logic            in_dec_valid;
    logic [RIW-1:0]  in_dec_src1_idx;
    logic            in_dec_src1_used;
    logic [RIW-1:0]  in_dec_src2_idx;
    logic            in_dec_src2_used;
    logic [RIW-1:0]  in_dec_res_idx;
    logic            in_dec_write_res;
    logic            in_ex_jump;
    logic            out_stall;
    logic            out_flush;
    logic            out_bubble;
    logic [NREG-1:0] out_busy;
    logic [1:0]      out_state;

    hazard_ctrl #(
        .REG_IDX_WIDTH (RIW),
        .WB_LATENCY    (LAT),
        .FLUSH_CYCLES  (FC),
        .WRITE_THROUGH (WT)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .in_dec_valid     (in_dec_valid),
        .in_dec_src1_idx  (in_dec_src1_idx),
        .in_dec_src1_used (in_dec_src1_used),
        .in_dec_src2_idx  (in_dec_src2_idx),
        .in_dec_src2_used (in_dec_src2_used),
        .in_dec_res_idx   (in_dec_res_idx),
        .in_dec_write_res (in_dec_write_res),
        .in_ex_jump       (in_ex_jump),
        .out_stall        (out_stall),
        .out_flush        (out_flush),
        .out_bubble       (out_bubble),
        .out_busy         (out_busy),
        .out_state        (out_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic            valid;
        logic [RIW-1:0]  s1;
        logic            s1u;
        logic [RIW-1:0]  s2;
        logic            s2u;
        logic [RIW-1:0]  res;
        logic            wr;
        logic            jump;
        logic            e_stall;
        logic            e_flush;
        logic            e_bubble;
        logic [1:0]      e_state;
        logic [NREG-1:0] e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic valid, input int s1, input logic s1u,
                                input int s2, input logic s2u, input int res, input logic wr,
                                input logic jump, input logic e_stall, input logic e_flush,
                                input logic e_bubble, input int e_state, input int e_busy);
        vec_t v;
        v.valid = valid; v.s1 = RIW'(s1); v.s1u = s1u; v.s2 = RIW'(s2); v.s2u = s2u;
        v.res = RIW'(res); v.wr = wr; v.jump = jump;
        v.e_stall = e_stall; v.e_flush = e_flush; v.e_bubble = e_bubble;
        v.e_state = 2'(e_state); v.e_busy = NREG'(e_busy);
        return v;
    endfunction

    task automatic drive(input logic valid, input logic [RIW-1:0] s1, input logic s1u,
                         input logic [RIW-1:0] s2, input logic s2u, input logic [RIW-1:0] res,
                         input logic wr, input logic jump);
        in_dec_valid     = valid;
        in_dec_src1_idx  = s1;
        in_dec_src1_used = s1u;
        in_dec_src2_idx  = s2;
        in_dec_src2_used = s2u;
        in_dec_res_idx   = res;
        in_dec_write_res = wr;
        in_ex_jump       = jump;
    endtask

    task automatic check_outs(input string tag, input logic st, input logic fl, input logic bb,
                              input logic [1:0] sta, input logic [NREG-1:0] bz);
        check($sformatf("%s stall", tag),  32'(out_stall),  32'(st));
        check($sformatf("%s flush", tag),  32'(out_flush),  32'(fl));
        check($sformatf("%s bubble", tag), 32'(out_bubble), 32'(bb));
        check($sformatf("%s state", tag),  32'(out_state),  32'(sta));
        check($sformatf("%s busy", tag),   32'(out_busy),   32'(bz));
    endtask

    // Reference model: pending writes stamped with their issue cycle, the
    // number of remaining flush cycles, and whether the previous cycle stalled.
    typedef struct {
        logic [RIW-1:0] idx;
        int             born;
    } wr_t;

    wr_t pend[$];
    int  now;
    int  flush_left;
    bit  stalled_prev;

    task automatic model_reset();
        pend.delete();
        now          = 0;
        flush_left   = 0;
        stalled_prev = 0;
    endtask

    task automatic model_step(output logic st, output logic fl, output logic bb,
                              output logic [1:0] sta, output logic [NREG-1:0] bz);
        bit hz;
        int age;
        int max_chk;
        max_chk = (WT != 0) ? LAT - 1 : LAT;
        sta = (flush_left > 0) ? 2'd2 : (stalled_prev ? 2'd1 : 2'd0);
        hz  = 0;
        bz  = '0;
        foreach (pend[i]) begin
            age = now - pend[i].born;
            if (age >= 1 && age <= LAT) bz[pend[i].idx] = 1'b1;
            if (age >= 1 && age <= max_chk && in_dec_valid &&
                ((in_dec_src1_used && in_dec_src1_idx == pend[i].idx) ||
                 (in_dec_src2_used && in_dec_src2_idx == pend[i].idx)))
                hz = 1;
        end
        st = 0; fl = 0; bb = 0;
        if (in_ex_jump) begin
            fl = 1; bb = 1;
            flush_left   = FC - 1;
            stalled_prev = 0;
        end else if (flush_left > 0) begin
            fl = 1; bb = 1;
            flush_left--;
            stalled_prev = 0;
        end else begin
            st = hz; bb = hz;
            stalled_prev = hz;
        end
        if (in_dec_valid && !st && !fl && in_dec_write_res) begin
            wr_t w;
            w.idx  = in_dec_res_idx;
            w.born = now;
            pend.push_back(w);
        end
        now++;
        while (pend.size() > 0 && (now - pend[0].born) > LAT) void'(pend.pop_front());
    endtask

    initial begin
        logic m_st, m_fl, m_bb;
        logic [1:0] m_sta;
        logic [NREG-1:0] m_bz;

        // Directed sequence from reset: RAW stall, no-hazard busy window,
        // jump flush, jump during stall, jump in the last flush cycle.
        //             vld s1 u  s2 u  res wr jmp  stl fl bb st busy
        vecs.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0,   0, 0, 0, 0, 'h00));
        vecs.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0,   1, 0, 1, 0, 'h08));
        vecs.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0,   1, 0, 1, 1, 'h08));
        vecs.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 'h08));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 'h00));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0,   0, 0, 0, 0, 'h00));
        vecs.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 'h08));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 'h08));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 'h08));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 'h00));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 1, 0, 'h00));
        vecs.push_back(mk(1, 0, 0, 0, 0, 6, 1, 0,   0, 1, 1, 2, 'h00));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 'h00));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 'h00));
        vecs.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0,   0, 0, 0, 0, 'h00));
        vecs.push_back(mk(1, 0, 0, 5, 1, 0, 0, 0,   1, 0, 1, 0, 'h20));
        vecs.push_back(mk(1, 0, 0, 5, 1, 0, 0, 1,   0, 1, 1, 1, 'h20));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 1, 2, 'h20));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 2, 'h00));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 'h00));

        // Reset with a jump pending on the input: every output must stay low.
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) @(posedge clock);
        #1;
        check_outs("reset", 0, 0, 0, 2'd0, '0);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clock);
            #1;
            drive(vecs[i].valid, vecs[i].s1, vecs[i].s1u, vecs[i].s2, vecs[i].s2u,
                  vecs[i].res, vecs[i].wr, vecs[i].jump);
            @(negedge clock);
            check_outs($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_flush,
                       vecs[i].e_bubble, vecs[i].e_state, vecs[i].e_busy);
        end

        // Reset in the middle of a stall.
        @(posedge clock); #1;
        drive(1, 0, 0, 0, 0, 7, 1, 0);
        @(posedge clock); #1;
        drive(1, 7, 1, 0, 0, 0, 0, 0);
        @(negedge clock);
        check("midstall pre stall", 32'(out_stall), 32'd1);
        #1 reset = 1'b1;
        #1;
        check_outs("midstall in_reset", 0, 0, 0, 2'd0, '0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        check_outs("midstall after", 0, 0, 0, 2'd0, '0);

        // Reset in the middle of a flush.
        @(posedge clock); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clock); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        check("midflush pre state", 32'(out_state), 32'd2);
        #1 reset = 1'b1;
        #1;
        check_outs("midflush in_reset", 0, 0, 0, 2'd0, '0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();

        // Randomized traffic on a small register range so hazards are frequent.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock); #1;
            drive(($urandom_range(0, 3) != 0),
                  RIW'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0),
                  RIW'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0),
                  RIW'(($urandom_range(0, 7) == 0) ? $urandom_range(0, NREG - 1) : $urandom_range(0, 3)),
                  ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 11) == 0));
            @(negedge clock);
            model_step(m_st, m_fl, m_bb, m_sta, m_bz);
            check_outs($sformatf("rnd%0d", c), m_st, m_fl, m_bb, m_sta, m_bz);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
